// File: rtl/pixel_win_counter_if.sv
// Pixel back-end signal bundle: arbiter win flag, frame/readout controls and the
// serial chain. The arbiter/readout side is the master and the pixel counter is the slave.
interface pixel_win_counter_if;
    // No valid/ready pairs here. frameSwap is a one-cycle strobe that is taken on the
    // edge where it is high. shiftEnable advances the chain once per high cycle.
    // winerAll is a level that is asynchronous to clk.
    logic winerAll;
    logic countEnable;
    logic frameSwap;
    logic shiftEnable;
    logic shiftIn;
    logic shiftOut;
    logic hitPulse;
    logic activeBank;
    logic overflow;

    modport master (
        output winerAll, countEnable, frameSwap, shiftEnable, shiftIn,
        input  shiftOut, hitPulse, activeBank, overflow
    );

    modport slave (
        input  winerAll, countEnable, frameSwap, shiftEnable, shiftIn,
        output shiftOut, hitPulse, activeBank, overflow
    );
endinterface

// File: rtl/pixel_win_counter.sv
// Per-pixel photon counter: synchronises the arbiter win flag and turns each rising edge into one hit.
// Hits go into ping-pong saturating banks, and the frozen bank is shifted out on a daisy chain.
module pixel_win_counter #(
    parameter int CNT_WIDTH   = 12,
    parameter int SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           rstn,
    pixel_win_counter_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   prevSync;
    logic                   synced;
    logic                   hitDet;
    logic                   countHit;
    logic                   hitPulseReg;

    logic                   bankSel;
    logic [CNT_WIDTH-1:0]   cnt0;
    logic [CNT_WIDTH-1:0]   cnt1;
    logic                   ovf0;
    logic                   ovf1;
    logic [CNT_WIDTH:0]     shiftReg;

    assign synced   = syncReg[SYNC_STAGES-1];
    assign hitDet   = synced & ~prevSync;
    assign countHit = hitDet & bus.countEnable;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            syncReg     <= '0;
            prevSync    <= 1'b0;
            hitPulseReg <= 1'b0;
        end else begin
            syncReg     <= {syncReg[SYNC_STAGES-2:0], bus.winerAll};
            prevSync    <= synced;
            hitPulseReg <= hitDet;
        end
    end

    // A swap clears the incoming bank. A hit on the same edge seeds that bank with 1,
    // so the hit is not lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bankSel  <= 1'b0;
            cnt0     <= '0;
            cnt1     <= '0;
            ovf0     <= 1'b0;
            ovf1     <= 1'b0;
            shiftReg <= '0;
        end else if (bus.frameSwap) begin
            bankSel <= ~bankSel;
            if (bankSel) begin
                cnt0     <= countHit ? CntOne : '0;
                ovf0     <= 1'b0;
                shiftReg <= {ovf1, cnt1};
            end else begin
                cnt1     <= countHit ? CntOne : '0;
                ovf1     <= 1'b0;
                shiftReg <= {ovf0, cnt0};
            end
        end else begin
            if (countHit) begin
                if (bankSel) begin
                    if (cnt1 == CntMax) ovf1 <= 1'b1;
                    else                cnt1 <= cnt1 + CntOne;
                end else begin
                    if (cnt0 == CntMax) ovf0 <= 1'b1;
                    else                cnt0 <= cnt0 + CntOne;
                end
            end
            if (bus.shiftEnable) begin
                shiftReg <= {shiftReg[CNT_WIDTH-1:0], bus.shiftIn};
            end
        end
    end

    assign bus.shiftOut   = shiftReg[CNT_WIDTH];
    assign bus.hitPulse   = hitPulseReg;
    assign bus.activeBank = bankSel;
    assign bus.overflow   = bankSel ? ovf1 : ovf0;
endmodule

// File: doc/pixel_win_counter.md
# pixel_win_counter

Per-pixel photon-count back end that consumes the arbiter's winner flag (`winerAll`). It synchronises the flag into the readout clock, converts each win into a single-cycle hit, and accumulates hits in a ping-pong pair of saturating counters so counting continues while the previous frame is read. It also shifts the frozen count out on a column-wise serial daisy chain. There is one instance per pixel, placed between the arbiter logic and the column readout chain.

## Interface
- `CNT_WIDTH`, 12: counter width in bits.
- `SYNC_STAGES`, 2: flip-flop stages in the `winerAll` synchroniser; minimum 2.

- `clk`  in  1: readout/count clock.
- `rstn`  in  1: synchronous, active-low reset.
- `winerAll`  in  1: arbiter winner flag; asynchronous to `clk`, level-high while the pixel holds the win.
- `countEnable`  in  1: gates counting; hits arriving while it is low are detected but not counted.
- `frameSwap`  in  1: single-cycle strobe; ends the current frame.
- `shiftEnable`  in  1: advances the readout shift register one bit per cycle.
- `shiftIn`  in  1: serial data from the upstream pixel.
- `shiftOut`  out  1: serial data to the downstream pixel; this is the MSB of the shift register.
- `hitPulse`  out  1: one-cycle pulse per detected win.
- `activeBank`  out  1: index (0/1) of the counter currently counting.
- `overflow`  out  1: sticky saturation flag of the active counter.

## Operation
- Synchroniser: `winerAll` passes through `SYNC_STAGES` flops, then one edge-detect flop.
- Rising-edge detect: `hitPulse` is registered and set when the synchronised value is 1 and the previous value was 0.
- A new hit requires `winerAll` to be sampled low for at least one cycle first.
- Two counters, `cnt0` and `cnt1`, each `CNT_WIDTH` bits, plus overflow bits `ovf0` and `ovf1`.
- The counter selected by `activeBank` increments on `hitPulse` when `countEnable` is 1.
- The counter saturates at 2^`CNT_WIDTH`−1. A hit arriving at that value leaves the count unchanged and sets the bank's overflow bit. The overflow bit is sticky until that bank is cleared.
- On `frameSwap`:
  - `activeBank` toggles.
  - The newly active counter and its overflow bit are cleared.
  - The frozen counter and its overflow bit are parallel-loaded into the shift register.
- Shift register: `CNT_WIDTH`+1 bits, ordered {ovf, cnt[MSB..0]}.
  - When `shiftEnable` is 1, the register shifts left and `shiftIn` enters at the LSB.
  - `shiftOut` always presents the current MSB.
- Load/shift priority: if `frameSwap` and `shiftEnable` are both 1 in the same cycle, the load wins and no shift occurs that cycle.
- Hit on the swap cycle: a hit coinciding with `frameSwap` is counted into the newly active counter, which ends that cycle at 1 rather than 0, so no hit is lost.
- Swap-with-no-hits: two `frameSwap` strobes with no hits between them load 0 with overflow 0.
- Reset (`rstn` low at a clock edge) clears:
  - all synchroniser and edge flops;
  - `cnt0`, `cnt1`, `ovf0`, `ovf1`;
  - the shift register;
  - `activeBank` to 0.
- Reset mid-frame or mid-shift discards all data; no partial frame is preserved.
- Resulting output values while and after reset: `shiftOut`=0, `hitPulse`=0, `activeBank`=0, `overflow`=0.

## Timing
- Let cycle T be the clock edge at which `winerAll` is first sampled high.
- `hitPulse` is high during the cycle following edge T+`SYNC_STAGES`.
- The counter shows the increment in that same cycle.
- `hitPulse` is exactly one cycle wide, regardless of how long `winerAll` stays high.
- Maximum count rate is one hit per `SYNC_STAGES`+... in practice one hit per 2 cycles, because a low sample is required between hits.
- `frameSwap` at edge S:
  - `activeBank`, the cleared counter and the loaded shift register are all visible after S.
  - `shiftOut` equals the frozen overflow bit in the cycle after S.
- Shifting: after k cycles with `shiftEnable` high, `shiftOut` equals bit (`CNT_WIDTH`−k) of {ovf, cnt}.
- Chain length for N pixels: N·(`CNT_WIDTH`+1) shift cycles read the whole chain.
- Reset takes effect at the first edge with `rstn` low.

## Test plan
- **Reset values:** hold `rstn`=0 for 3 cycles with `winerAll`=1 → all outputs 0 and no `hitPulse`. After release, the first `hitPulse` arrives at cycle `SYNC_STAGES`+1.
- **Basic count:** send 5 `winerAll` pulses, each 3 cycles high and 2 low, with `countEnable`=1. Then `frameSwap`, then 13 `shiftEnable` cycles → the serial stream is 0,000000000101 (MSB first) and `activeBank`=1.
- **Saturation:** with `CNT_WIDTH`=4, send 17 hits → the count holds at 15 and `overflow`=1. After `frameSwap`, the shifted word is 1,1111 and the new bank has `overflow`=0.
- **Swap/hit coincidence:** time a hit so `hitPulse` lands on the `frameSwap` cycle → the old bank is frozen at its prior value and the new bank reads 1.
- **Gating:** send 4 hits with `countEnable`=0 → 4 `hitPulse` pulses and a count of 0.
- **Daisy chain and load priority:** chain 3 instances with counts 1, 2, 3; run 39 shift cycles → the last instance's `shiftOut` emits 3, then 2, then 1, 13 bits each. Asserting `frameSwap` together with `shiftEnable` → load occurs with no shift.
